// File: rtl/tx_debounce_multi.sv
// -----------------------------------------------------------------------------
// tx_debounce_multi
//
// N-channel switch/button debouncer for the UART TX control path. Each channel
// runs its raw input through a 2-flop synchroniser. It then requires a run of
// counted samples of a new level before the debounced output follows.
//
// Counting, per channel:
//   - While the synchronised level matches the debounced level, the counter
//     is held at zero.
//   - While the levels differ, the counter advances only on edges where
//     i_Tick is high. This lets a slow strobe prescale the debounce window.
//   - The edge that would take the counter past DEBOUNCE_CYCLES-1 commits the
//     new level and fires a one-cycle rise or fall pulse.
//   - Any sample that agrees with the debounced level before then restarts
//     the count.
//
// Ports:
//   i_Clk        - system clock, rising edge
//   i_Reset      - synchronous active-high reset
//   i_Tick       - count enable / prescale strobe (tie high to count every clock)
//   i_Switch     - raw asynchronous switch inputs, one bit per channel
//   o_Stable     - debounced levels
//   o_Rise       - one-cycle pulse when o_Stable[c] goes 0->1
//   o_Fall       - one-cycle pulse when o_Stable[c] goes 1->0
//   o_Any_Change - OR of all rise/fall pulses, same cycle
// -----------------------------------------------------------------------------
module tx_debounce_multi #(
    parameter int   N_CH            = 1,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic            i_Tick,
    input  logic [N_CH-1:0] i_Switch,
    output logic [N_CH-1:0] o_Stable,
    output logic [N_CH-1:0] o_Rise,
    output logic [N_CH-1:0] o_Fall,
    output logic            o_Any_Change
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Last counter value before qualification. The qualifying edge itself is
    // the DEBOUNCE_CYCLES-th counted sample, so the counter never reaches
    // DEBOUNCE_CYCLES.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]         sync1;
    logic [N_CH-1:0]         sync2;
    logic [N_CH-1:0]         stable;
    logic [N_CH-1:0]         rise;
    logic [N_CH-1:0]         fall;
    logic [N_CH-1:0][CW-1:0] cnt;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1  <= {N_CH{RESET_VAL}};
            sync2  <= {N_CH{RESET_VAL}};
            stable <= {N_CH{RESET_VAL}};
            rise   <= '0;
            fall   <= '0;
            cnt    <= '0;
        end else begin
            sync1 <= i_Switch;
            sync2 <= sync1;
            for (int c = 0; c < N_CH; c++) begin
                // Pulses last exactly one cycle unless re-armed below.
                rise[c] <= 1'b0;
                fall[c] <= 1'b0;
                if (sync2[c] == stable[c]) begin
                    // Agreement (including the end of a glitch) restarts the
                    // count even without a tick.
                    cnt[c] <= '0;
                end else if (i_Tick) begin
                    if (cnt[c] == CNT_LAST) begin
                        stable[c] <= sync2[c];
                        cnt[c]    <= '0;
                        rise[c]   <= sync2[c];
                        fall[c]   <= ~sync2[c];
                    end else begin
                        cnt[c] <= cnt[c] + CW'(1);
                    end
                end
            end
        end
    end

    assign o_Stable     = stable;
    assign o_Rise       = rise;
    assign o_Fall       = fall;
    assign o_Any_Change = |(rise | fall);

endmodule

// File: tb/tb_tx_debounce_multi.sv
// -----------------------------------------------------------------------------
// Bench for tx_debounce_multi with N_CH=4, DEBOUNCE_CYCLES=10, RESET_VAL=0.
//
// A behavioural model sees each edge's inputs and pushes the expected
// {stable, rise, fall, any} word into exp_q. The model treats the synchroniser
// as a two-deep queue of past inputs and counts "ticked samples that disagree
// with the debounced level". After every edge, the DUT outputs are compared
// against the popped word.
//
// A stimulus table with hand-derived end-of-segment expectations covers:
//   - reset
//   - basic rise and fall
//   - simultaneous channels
//   - bounce
//   - reset in mid-count
//
// Hand-written sequences cover the prescaled-tick latency and the glitch
// restart. A randomized phase exercises the model at length.
// -----------------------------------------------------------------------------
module tb_tx_debounce_multi;

    localparam int N_CH = 4;
    localparam int DB   = 10;

    logic            clk;
    logic            rst;
    logic            tick;
    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] st;
    logic [N_CH-1:0] ri;
    logic [N_CH-1:0] fa;
    logic            any;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    tx_debounce_multi #(
        .N_CH(N_CH),
        .DEBOUNCE_CYCLES(DB),
        .RESET_VAL(1'b0)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Tick(tick),
        .i_Switch(sw),
        .o_Stable(st),
        .o_Rise(ri),
        .o_Fall(fa),
        .o_Any_Change(any)
    );

    // ---------------- reference model + scoreboard ----------------
    logic [N_CH-1:0] seen_q[$];   // inputs not yet visible past the synchroniser
    logic [N_CH-1:0] m_stable;
    int              m_streak [N_CH];
    logic [3*N_CH:0] exp_q[$];

    task automatic model_reset();
        seen_q   = {};
        seen_q.push_back('0);
        seen_q.push_back('0);
        m_stable = '0;
        for (int c = 0; c < N_CH; c++) m_streak[c] = 0;
    endtask

    // One clock edge of the model: the level that reaches the counter now is
    // the input sampled two edges ago.
    task automatic model_edge(input logic r, input logic t, input logic [N_CH-1:0] s);
        logic [N_CH-1:0] samp;
        logic [N_CH-1:0] er;
        logic [N_CH-1:0] ef;
        er = '0;
        ef = '0;
        if (r) begin
            model_reset();
        end else begin
            samp = seen_q.pop_front();
            seen_q.push_back(s);
            for (int c = 0; c < N_CH; c++) begin
                if (samp[c] == m_stable[c]) begin
                    m_streak[c] = 0;
                end else if (t) begin
                    m_streak[c]++;
                    if (m_streak[c] == DB) begin
                        m_stable[c] = samp[c];
                        m_streak[c] = 0;
                        er[c]       = samp[c];
                        ef[c]       = ~samp[c];
                    end
                end
            end
        end
        exp_q.push_back({m_stable, er, ef, |(er | ef)});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic t, input logic [N_CH-1:0] s);
        logic [3*N_CH:0] e;
        @(negedge clk);
        rst  = r;
        tick = t;
        sw   = s;
        @(posedge clk);
        model_edge(r, t, s);
        #1;
        e = exp_q.pop_front();
        check("model", {19'b0, st, ri, fa, any}, {19'b0, e});
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic            r;
        logic            t;
        logic [N_CH-1:0] s;
        int              reps;
        logic [N_CH-1:0] e_st;
        logic [N_CH-1:0] e_ri;
        logic [N_CH-1:0] e_fa;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic t, logic [N_CH-1:0] s, int reps,
                                logic [N_CH-1:0] e_st, logic [N_CH-1:0] e_ri,
                                logic [N_CH-1:0] e_fa);
        vec_t v;
        v.r    = r;
        v.t    = t;
        v.s    = s;
        v.reps = reps;
        v.e_st = e_st;
        v.e_ri = e_ri;
        v.e_fa = e_fa;
        return v;
    endfunction

    // Prescaled tick (1 in 4) with ch0 high from edge 0. With a glitch, ch0
    // drops for edges 20-21, so counted samples restart and qualification
    // moves from edge 39 to edge 63.
    task automatic tick_seq(input bit glitch);
        int rise_k;
        rise_k = glitch ? 63 : 39;
        step(1'b1, 1'b1, 4'h0);
        step(1'b1, 1'b1, 4'h0);
        for (int k = 0; k <= rise_k + 1; k++) begin
            step(1'b0, (k % 4) == 3, (glitch && (k == 20 || k == 21)) ? 4'h0 : 4'h1);
            if (k == rise_k - 1) check(glitch ? "tick_glitch_early" : "tick_early", {31'b0, st[0]}, 32'd0);
            if (k == rise_k) check(glitch ? "tick_glitch_rise" : "tick_rise", {28'b0, st, ri[0], any}, 32'h0000000F & {28'b0, 4'h0} | 32'd7);
        end
    endtask

    logic [N_CH-1:0] rnd_sw;

    initial begin
        rst  = 1'b1;
        tick = 1'b1;
        sw   = '0;
        model_reset();

        tbl.push_back(mk(1, 1, 4'h0, 3,  4'h0, 4'h0, 4'h0)); // reset
        tbl.push_back(mk(0, 1, 4'h1, 11, 4'h0, 4'h0, 4'h0)); // ch0 up, 1 edge short
        tbl.push_back(mk(0, 1, 4'h1, 1,  4'h1, 4'h1, 4'h0)); // E0+11
        tbl.push_back(mk(0, 1, 4'h1, 1,  4'h1, 4'h0, 4'h0)); // pulse gone
        tbl.push_back(mk(0, 1, 4'h0, 11, 4'h1, 4'h0, 4'h0)); // ch0 down
        tbl.push_back(mk(0, 1, 4'h0, 1,  4'h0, 4'h0, 4'h1));
        tbl.push_back(mk(0, 1, 4'h0, 1,  4'h0, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1, 4'hC, 11, 4'h0, 4'h0, 4'h0)); // ch2+ch3 together
        tbl.push_back(mk(0, 1, 4'hC, 1,  4'hC, 4'hC, 4'h0));
        tbl.push_back(mk(0, 1, 4'hC, 1,  4'hC, 4'h0, 4'h0));
        for (int i = 0; i < 3; i++) begin                    // ch1 bounce
            tbl.push_back(mk(0, 1, 4'hE, 6, 4'hC, 4'h0, 4'h0));
            tbl.push_back(mk(0, 1, 4'hC, 2, 4'hC, 4'h0, 4'h0));
        end
        tbl.push_back(mk(0, 1, 4'hE, 11, 4'hC, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1, 4'hE, 1,  4'hE, 4'h2, 4'h0));
        tbl.push_back(mk(0, 1, 4'hE, 1,  4'hE, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1, 4'hF, 9,  4'hE, 4'h0, 4'h0)); // ch0 count at 7
        tbl.push_back(mk(1, 1, 4'hF, 1,  4'h0, 4'h0, 4'h0)); // reset mid-count
        tbl.push_back(mk(0, 1, 4'hF, 11, 4'h0, 4'h0, 4'h0)); // full latency again
        tbl.push_back(mk(0, 1, 4'hF, 1,  4'hF, 4'hF, 4'h0));
        tbl.push_back(mk(0, 1, 4'hF, 1,  4'hF, 4'h0, 4'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].reps; k++) step(tbl[i].r, tbl[i].t, tbl[i].s);
            check($sformatf("tbl[%0d]", i), {19'b0, st, ri, fa, any},
                  {19'b0, tbl[i].e_st, tbl[i].e_ri, tbl[i].e_fa, |(tbl[i].e_ri | tbl[i].e_fa)});
        end

        tick_seq(1'b0);
        tick_seq(1'b1);

        // Randomized phase: slowly toggling channels, mostly-high tick, rare reset.
        rnd_sw = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(0, 15) == 0) rnd_sw[c] = ~rnd_sw[c];
            step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, rnd_sw);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net in case a wait never returns.
    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
